// File: rtl/expr_harness_pkg.sv
// Shared constants, operand layout and FSM state type for the expression-vector harness.
package expr_harness_pkg;

  localparam int unsigned STIM_W = 60;
  localparam int unsigned Y_W    = 90;

  // LFSR polynomial x^60 + x^59 + 1
  localparam int unsigned LFSR_TAP_HI = 59;
  localparam int unsigned LFSR_TAP_LO = 58;

  // MISR feedback taps
  localparam int unsigned MISR_TAP_0 = 89;
  localparam int unsigned MISR_TAP_1 = 88;
  localparam int unsigned MISR_TAP_2 = 87;
  localparam int unsigned MISR_TAP_3 = 86;

  // Operand slice offsets/widths within the LFSR state
  localparam int unsigned A0_OFF = 0;   localparam int unsigned A0_W = 4;
  localparam int unsigned A1_OFF = 4;   localparam int unsigned A1_W = 5;
  localparam int unsigned A2_OFF = 9;   localparam int unsigned A2_W = 6;
  localparam int unsigned A3_OFF = 15;  localparam int unsigned A3_W = 4;
  localparam int unsigned A4_OFF = 19;  localparam int unsigned A4_W = 5;
  localparam int unsigned A5_OFF = 24;  localparam int unsigned A5_W = 6;
  localparam int unsigned B0_OFF = 30;  localparam int unsigned B0_W = 4;
  localparam int unsigned B1_OFF = 34;  localparam int unsigned B1_W = 5;
  localparam int unsigned B2_OFF = 39;  localparam int unsigned B2_W = 6;
  localparam int unsigned B3_OFF = 45;  localparam int unsigned B3_W = 4;
  localparam int unsigned B4_OFF = 49;  localparam int unsigned B4_W = 5;
  localparam int unsigned B5_OFF = 54;  localparam int unsigned B5_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One LFSR shift step
  function automatic logic [STIM_W-1:0] lfsr_step(input logic [STIM_W-1:0] s);
    return {s[STIM_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/expr_misr.sv
// 90-bit multiple-input signature register with enable and synchronous clear.
module expr_misr
  import expr_harness_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clr,
  input  logic [Y_W-1:0] y,
  output logic [Y_W-1:0] sig
);

  logic [Y_W-1:0] sig_q;
  logic [Y_W-1:0] sig_d;
  logic           fb;

  // Next signature: clear wins, then fold y into the shifted state
  always_comb begin
    fb    = sig_q[MISR_TAP_0] ^ sig_q[MISR_TAP_1] ^ sig_q[MISR_TAP_2] ^ sig_q[MISR_TAP_3];
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[Y_W-2:0], fb} ^ y;
    end
  end

  // Signature register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/expr_vector_harness.sv
// Drives a combinational expression DUT from an LFSR and compacts its result into a MISR.
module expr_vector_harness
  import expr_harness_pkg::*;
#(
  parameter int unsigned VEC_COUNT = 256
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [STIM_W-1:0]                   seed,
  output logic [A0_W-1:0]                     a0,
  output logic [A1_W-1:0]                     a1,
  output logic [A2_W-1:0]                     a2,
  output logic signed [A3_W-1:0]              a3,
  output logic signed [A4_W-1:0]              a4,
  output logic signed [A5_W-1:0]              a5,
  output logic [B0_W-1:0]                     b0,
  output logic [B1_W-1:0]                     b1,
  output logic [B2_W-1:0]                     b2,
  output logic signed [B3_W-1:0]              b3,
  output logic signed [B4_W-1:0]              b4,
  output logic signed [B5_W-1:0]              b5,
  input  logic [Y_W-1:0]                      y,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(VEC_COUNT+1)-1:0]      vec_idx,
  output logic [Y_W-1:0]                      signature
);

  localparam int unsigned IDX_W = $clog2(VEC_COUNT + 1);

  state_e              state_q, state_d;
  logic [STIM_W-1:0]   lfsr_q,  lfsr_d;
  logic [IDX_W-1:0]    cnt_q,   cnt_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                misr_en_c;
  logic                misr_clr_c;

  // Next-state, LFSR, counter and MISR control; abort overrides everything else
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    misr_en_c  = 1'b0;
    misr_clr_c = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            lfsr_d     = (seed == '0) ? STIM_W'(1) : seed;
            misr_clr_c = 1'b1;
            cnt_d      = '0;
            state_d    = RUN;
          end
        end
        RUN: begin
          misr_en_c = 1'b1;
          cnt_d     = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(VEC_COUNT - 1)) begin
            // Last vector stays on the operands while DONE is held
            state_d = DONE;
          end else begin
            lfsr_d = lfsr_step(lfsr_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, stimulus and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  expr_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (misr_en_c),
    .clr   (misr_clr_c),
    .y     (y),
    .sig   (signature)
  );

  assign a0 = lfsr_q[A0_OFF +: A0_W];
  assign a1 = lfsr_q[A1_OFF +: A1_W];
  assign a2 = lfsr_q[A2_OFF +: A2_W];
  assign a3 = $signed(lfsr_q[A3_OFF +: A3_W]);
  assign a4 = $signed(lfsr_q[A4_OFF +: A4_W]);
  assign a5 = $signed(lfsr_q[A5_OFF +: A5_W]);
  assign b0 = lfsr_q[B0_OFF +: B0_W];
  assign b1 = lfsr_q[B1_OFF +: B1_W];
  assign b2 = lfsr_q[B2_OFF +: B2_W];
  assign b3 = $signed(lfsr_q[B3_OFF +: B3_W]);
  assign b4 = $signed(lfsr_q[B4_OFF +: B4_W]);
  assign b5 = $signed(lfsr_q[B5_OFF +: B5_W]);

  assign busy    = busy_q;
  assign done    = done_q;
  assign vec_idx = cnt_q;

endmodule

// File: tb/tb_expr_vector_harness.sv
// Scoreboard bench: a short-run harness (4 vectors) and a full-length one (256 vectors).
module tb_expr_vector_harness;

  localparam int unsigned N4   = 4;
  localparam int unsigned N256 = 256;
  localparam int unsigned IW4   = $clog2(N4 + 1);
  localparam int unsigned IW256 = $clog2(N256 + 1);

  typedef struct packed { logic [59:0] vec; logic [31:0] idx; } vec_t;
  typedef struct packed { logic [89:0] sig; logic [31:0] idx; } end_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  function automatic logic [89:0] golden(input logic [59:0] s);
    logic [29:0] lo, hi;
    lo = s[29:0];
    hi = s[59:30];
    return {30'(hi + lo), s ^ {s[0], s[59:1]}};
  endfunction

  function automatic logic [89:0] y_of(input int mode, input logic [59:0] v);
    if (mode == 0) return 90'd0;
    if (mode == 1) return 90'd1;
    return golden(v);
  endfunction

  function automatic logic [59:0] nth_vec(input logic [59:0] seed, input int n);
    logic [59:0] v;
    v = (seed == 60'd0) ? 60'd1 : seed;
    for (int i = 0; i < n; i++) v = {v[58:0], v[59] ^ v[58]};
    return v;
  endfunction

  function automatic logic [89:0] ref_sig(input logic [59:0] seed, input int mode, input int ncap);
    logic [89:0] m;
    m = 90'd0;
    for (int i = 0; i < ncap; i++)
      m = {m[88:0], m[89] ^ m[88] ^ m[87] ^ m[86]} ^ y_of(mode, nth_vec(seed, i));
    return m;
  endfunction

  // ---------------- DUT with VEC_COUNT=4 ----------------
  logic        start4 = 1'b0, abort4 = 1'b0;
  logic [59:0] seed4 = '0;
  int          mode4 = 0;
  logic [3:0]  a0_4, b0_4;
  logic [4:0]  a1_4, b1_4;
  logic [5:0]  a2_4, b2_4;
  logic signed [3:0] a3_4, b3_4;
  logic signed [4:0] a4_4, b4_4;
  logic signed [5:0] a5_4, b5_4;
  logic [89:0] y4, sig4;
  logic        busy4, done4;
  logic [IW4-1:0] vidx4;
  logic [59:0] stim4;

  assign stim4 = {b5_4, b4_4, b3_4, b2_4, b1_4, b0_4, a5_4, a4_4, a3_4, a2_4, a1_4, a0_4};
  always_comb y4 = y_of(mode4, stim4);

  expr_vector_harness #(.VEC_COUNT(N4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .seed(seed4),
    .a0(a0_4), .a1(a1_4), .a2(a2_4), .a3(a3_4), .a4(a4_4), .a5(a5_4),
    .b0(b0_4), .b1(b1_4), .b2(b2_4), .b3(b3_4), .b4(b4_4), .b5(b5_4),
    .y(y4), .busy(busy4), .done(done4), .vec_idx(vidx4), .signature(sig4)
  );

  // ---------------- DUT with VEC_COUNT=256 ----------------
  logic        start256 = 1'b0, abort256 = 1'b0;
  logic [59:0] seed256 = '0;
  logic [3:0]  a0_g, b0_g;
  logic [4:0]  a1_g, b1_g;
  logic [5:0]  a2_g, b2_g;
  logic signed [3:0] a3_g, b3_g;
  logic signed [4:0] a4_g, b4_g;
  logic signed [5:0] a5_g, b5_g;
  logic [89:0] y256, sig256;
  logic        busy256, done256;
  logic [IW256-1:0] vidx256;
  logic [59:0] stim256;

  assign stim256 = {b5_g, b4_g, b3_g, b2_g, b1_g, b0_g, a5_g, a4_g, a3_g, a2_g, a1_g, a0_g};
  always_comb y256 = golden(stim256);

  expr_vector_harness #(.VEC_COUNT(N256)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .abort(abort256), .seed(seed256),
    .a0(a0_g), .a1(a1_g), .a2(a2_g), .a3(a3_g), .a4(a4_g), .a5(a5_g),
    .b0(b0_g), .b1(b1_g), .b2(b2_g), .b3(b3_g), .b4(b4_g), .b5(b5_g),
    .y(y256), .busy(busy256), .done(done256), .vec_idx(vidx256), .signature(sig256)
  );

  // ---------------- scoreboard queues ----------------
  vec_t q_vec4[$];
  end_t q_end4[$];
  vec_t q_vec256[$];
  end_t q_end256[$];

  task automatic push4(input logic [59:0] seed, input int mode, input int nvec, input bit with_end);
    for (int i = 0; i < nvec; i++) q_vec4.push_back('{vec: nth_vec(seed, i), idx: 32'(i)});
    if (with_end) q_end4.push_back('{sig: ref_sig(seed, mode, int'(N4)), idx: 32'(N4)});
  endtask

  task automatic push256(input logic [59:0] seed);
    for (int i = 0; i < int'(N256); i++) q_vec256.push_back('{vec: nth_vec(seed, i), idx: 32'(i)});
    q_end256.push_back('{sig: ref_sig(seed, 2, int'(N256)), idx: 32'(N256)});
  endtask

  // ---------------- monitor ----------------
  logic done4_prev = 1'b0, done256_prev = 1'b0;

  always @(negedge clk) begin
    vec_t ev;
    end_t ee;
    if (busy4) begin
      checks++;
      if (q_vec4.size() == 0) begin
        errors++;
        $display("FAIL vec4_unexpected: busy with operands %h, no vector expected", stim4);
      end else begin
        ev = q_vec4.pop_front();
        if (stim4 !== ev.vec || vidx4 !== IW4'(ev.idx)) begin
          errors++;
          $display("FAIL vec4: got vec %h idx %0d, want vec %h idx %0d", stim4, vidx4, ev.vec, ev.idx);
        end
      end
    end
    if (done4 && !done4_prev) begin
      checks++;
      if (q_end4.size() == 0) begin
        errors++;
        $display("FAIL end4_unexpected: done rose with signature %h", sig4);
      end else begin
        ee = q_end4.pop_front();
        if (sig4 !== ee.sig || vidx4 !== IW4'(ee.idx) || busy4 !== 1'b0) begin
          errors++;
          $display("FAIL end4: got sig %h idx %0d busy %b, want sig %h idx %0d busy 0",
                   sig4, vidx4, busy4, ee.sig, ee.idx);
        end
      end
    end
    done4_prev = done4;

    if (busy256) begin
      checks++;
      if (q_vec256.size() == 0) begin
        errors++;
        $display("FAIL vec256_unexpected: busy with operands %h", stim256);
      end else begin
        ev = q_vec256.pop_front();
        if (stim256 !== ev.vec || vidx256 !== IW256'(ev.idx)) begin
          errors++;
          $display("FAIL vec256: got vec %h idx %0d, want vec %h idx %0d", stim256, vidx256, ev.vec, ev.idx);
        end
      end
    end
    if (done256 && !done256_prev) begin
      checks++;
      if (q_end256.size() == 0) begin
        errors++;
        $display("FAIL end256_unexpected: done rose with signature %h", sig256);
      end else begin
        ee = q_end256.pop_front();
        if (sig256 !== ee.sig || vidx256 !== IW256'(ee.idx)) begin
          errors++;
          $display("FAIL end256: got sig %h idx %0d, want sig %h idx %0d", sig256, vidx256, ee.sig, ee.idx);
        end
      end
    end
    done256_prev = done256;
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic start_run4(input logic [59:0] s, input int m);
    mode4  = m;
    seed4  = s;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done4(input int budget);
    int n;
    n = 0;
    while (!done4 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done4_timeout", 128'(done4), 128'(1'b1));
  endtask

  task automatic wait_done256(input int budget);
    int n;
    n = 0;
    while (!done256 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done256_timeout", 128'(done256), 128'(1'b1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [59:0] rs;
    logic [89:0] first_sig;
    int n;

    // Reset state
    #12;
    check("rst_busy", 128'(busy4), 128'(1'b0));
    check("rst_done", 128'(done4), 128'(1'b0));
    check("rst_operands", 128'(stim4), 128'(0));
    check("rst_sig", 128'(sig4), 128'(0));
    check("rst_vidx", 128'(vidx4), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // seed=1, y=0: walking-one operands, zero signature
    push4(60'd1, 0, int'(N4), 1'b1);
    start_run4(60'd1, 0);
    wait_done4(20);
    check("y0_sig", 128'(sig4), 128'(0));
    check("y0_operands", 128'(stim4), 128'(60'h8));

    // seed=1, y=1, restarted from DONE: signature 0xF
    push4(60'd1, 1, int'(N4), 1'b1);
    start_run4(60'd1, 1);
    check("restart_done_drop", 128'(done4), 128'(1'b0));
    wait_done4(20);
    check("y1_sig", 128'(sig4), 128'(90'hF));

    // zero seed substitutes 1
    push4(60'd0, 1, int'(N4), 1'b1);
    start_run4(60'd0, 1);
    wait_done4(20);
    check("seed0_sig", 128'(sig4), 128'(90'hF));

    // abort at vec_idx=2, with an ignored start pulse during RUN
    push4(60'd1, 1, 3, 1'b0);
    start_run4(60'd1, 1);
    n = 0;
    while (vidx4 != IW4'(1) && n < 10) begin @(negedge clk); n++; end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("abort_reach_idx2", 128'(vidx4), 128'(2));
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check("abort_busy", 128'(busy4), 128'(1'b0));
    check("abort_sig", 128'(sig4), 128'(90'h3));
    check("abort_vidx", 128'(vidx4), 128'(2));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", 128'(done4), 128'(1'b0));
    end

    // reset mid-run: outputs clear immediately
    rs = {28'($urandom), 32'($urandom)};
    push4(rs, 2, 2, 1'b0);
    start_run4(rs, 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 128'(busy4), 128'(1'b0));
    check("midrst_operands", 128'(stim4), 128'(0));
    check("midrst_sig", 128'(sig4), 128'(0));
    check("midrst_vidx", 128'(vidx4), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push4(60'd1, 1, int'(N4), 1'b1);
    start_run4(60'd1, 1);
    wait_done4(20);
    check("postrst_sig", 128'(sig4), 128'(90'hF));

    // randomized seeds with a data-dependent result
    for (int r = 0; r < 6; r++) begin
      rs = (r == 2) ? 60'd0 : {28'($urandom), 32'($urandom)};
      push4(rs, 2, int'(N4), 1'b1);
      start_run4(rs, 2);
      wait_done4(20);
    end

    // full-length run against the reference signature, then restart from DONE
    for (int r = 0; r < 2; r++) begin
      seed256  = 60'h0AB_CDEF_0123_4567;
      push256(seed256);
      start256 = 1'b1;
      @(negedge clk);
      start256 = 1'b0;
      wait_done256(400);
      if (r == 0) first_sig = sig256;
      else check("restart256_same_sig", 128'(sig256), 128'(first_sig));
    end

    repeat (2) @(negedge clk);
    check("queues_drained", 128'(q_vec4.size() + q_end4.size() + q_vec256.size() + q_end256.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_vector_harness.md
Name: expr_vector_harness

Overview:
- Opposite end of a vloghammer expression_NNNNN combinational DUT.
- Drives the twelve DUT operand inputs (a0..a5, b0..b5; 60 bits total) from a 60-bit LFSR, one new vector per clock.
- Compacts the returned 90-bit packed result y into a 90-bit MISR signature.
- Used in regression to compare LiveHD-synthesised netlists against golden RTL by signature, with a start/done handshake to the test controller.

Parameters:
- VEC_COUNT, 256, number of vectors applied per run (>=1).
- STIM_W, 60, total operand width; fixed by the a0..b5 layout.
- Y_W, 90, width of the DUT packed result.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin run; sampled in IDLE or DONE only
- abort  in  1  synchronous abort; returns to IDLE without done
- seed  in  60  LFSR seed, sampled on accepted start
- a0 out 4, a1 out 5, a2 out 6, a3 out 4 (signed), a4 out 5 (signed), a5 out 6 (signed)  DUT operand A group
- b0 out 4, b1 out 5, b2 out 6, b3 out 4 (signed), b4 out 5 (signed), b5 out 6 (signed)  DUT operand B group
- y  in  90  DUT result, combinational from a*/b*
- busy  out  1  high in RUN
- done  out  1  high in DONE; held until the next start or abort
- vec_idx  out  clog2(VEC_COUNT+1)  number of vectors captured so far in this run
- signature  out  90  MISR state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lfsr=0 (so all a*/b* = 0), misr=0, vec_idx=0, busy=0, done=0. Reset mid-RUN discards the run.
- Operand mapping from the registered lfsr:
  - a0=[3:0], a1=[8:4], a2=[14:9], a3=[18:15], a4=[23:19], a5=[29:24]
  - b0=[33:30], b1=[38:34], b2=[44:39], b3=[48:45], b4=[53:49], b5=[59:54]
  - All operands are direct flop outputs.
- LFSR step: lfsr_next = {lfsr[58:0], lfsr[59]^lfsr[58]} (x^60+x^59+1).
- MISR step: fb = misr[89]^misr[88]^misr[87]^misr[86]; misr_next = {misr[88:0], fb} ^ y.
- IDLE:
  - busy=0, done=0; operands hold their last value.
  - start=1 at edge: lfsr<=seed (if seed==0 then 60'd1), misr<=0, vec_idx<=0, go RUN.
- RUN: busy=1. At each edge:
  - misr<=misr_next (captures y for the vector currently driven), lfsr<=lfsr_next, vec_idx<=vec_idx+1.
  - On the edge where vec_idx becomes VEC_COUNT, go DONE; lfsr does not advance on that edge.
  - start is ignored in RUN.
- DONE:
  - done=1; signature, operands and vec_idx are frozen.
  - start restarts exactly as from IDLE; done drops on the same edge.
- abort=1 in any state: next state IDLE, misr and lfsr held, vec_idx held. abort has priority over start and over the RUN capture/terminal-count update.
- Latency: start accepted at edge k; first vector valid after edge k; y captured at edges k+1..k+VEC_COUNT; done=1 after edge k+VEC_COUNT.
- VEC_COUNT=1: one capture, then DONE.
- Arithmetic is purely XOR/shift; no width growth.

Decomposition:
- Package expr_harness_pkg:
  - STIM_W, Y_W, LFSR and MISR tap constants
  - operand slice offsets/widths
  - state enum {IDLE, RUN, DONE}
- Sub-module expr_misr (90-bit, enable, synchronous clear, async reset). The LFSR, counter and FSM stay in the top.

Test Plan:
- Reset, then seed=1, VEC_COUNT=4, y tied to 0 -> lfsr sequence 0x1,0x2,0x4,0x8 on a0..b5; signature=0; done after 4 RUN cycles; vec_idx=4.
- seed=1, VEC_COUNT=4, y=90'd1 constant -> misr sequence 1,3,7,0xF; final signature=90'hF.
- seed=0 -> first vector equals 60'd1 (zero-seed substitution); sequence identical to the seed=1 run.
- abort asserted at vec_idx=2 -> IDLE next cycle, busy=0, done never asserts, signature=3 (y=1 case); start pulsed during RUN has no effect.
- rst_n pulled low mid-RUN -> immediate busy=0, operands=0, signature=0, vec_idx=0; a new start afterwards reproduces the golden run.
- Golden-DUT loop, VEC_COUNT=256, fixed seed -> signature matches the reference-model MISR bit-exactly; restart from DONE reproduces the same signature.
